// File: rtl/fetch_pc_unit_pkg.sv
// Shared CPU constants and next-PC source encoding used by the fetch path.
package cpu_defs;

  localparam logic [31:0] PC_DEFAULT     = 32'h0000_3000;
  localparam logic [31:0] CPU_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] CPU_PC_LOW     = 32'h0000_3000;
  localparam logic [31:0] CPU_PC_HIGH    = 32'h0000_6FFC;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_J    = 3'd2,
    NPC_JR   = 3'd3,
    NPC_EXC  = 3'd4,
    NPC_ERET = 3'd5,
    NPC_PEND = 3'd6,
    NPC_HOLD = 3'd7
  } npc_src_e;

endpackage

// File: rtl/fetch_pc_unit_npc_select.sv
// Combinational next-PC priority mux: exception > eret > stall > live redirect > buffered redirect > pc+4.
module npc_select
  import cpu_defs::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  EXC_VECTOR = WIDTH'(CPU_EXC_VECTOR)
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             j_en,
  input  logic [WIDTH-1:0] j_target,
  input  logic             jr_en,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  output logic [WIDTH-1:0] npc,
  output npc_src_e         src,
  output logic             rd_req,
  output logic [WIDTH-1:0] rd_tgt
);

  npc_src_e rd_src;

  always_comb begin
    rd_req = 1'b0;
    rd_tgt = '0;
    rd_src = NPC_SEQ;
    if (jr_en) begin
      rd_req = 1'b1;
      rd_tgt = jr_target;
      rd_src = NPC_JR;
    end else if (j_en) begin
      rd_req = 1'b1;
      rd_tgt = j_target;
      rd_src = NPC_J;
    end else if (br_taken) begin
      rd_req = 1'b1;
      rd_tgt = br_target;
      rd_src = NPC_BR;
    end
  end

  always_comb begin
    npc = pc_plus4;
    src = NPC_SEQ;
    if (exc_req) begin
      npc = EXC_VECTOR;
      src = NPC_EXC;
    end else if (eret) begin
      npc = epc_in;
      src = NPC_ERET;
    end else if (stall) begin
      npc = pc;
      src = NPC_HOLD;
    end else if (rd_req) begin
      npc = rd_tgt;
      src = rd_src;
    end else if (pend_valid) begin
      npc = pend_target;
      src = NPC_PEND;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program-counter register with stall hold, buffered redirect and fetch-address legality flag.
module fetch_pc_unit
  import cpu_defs::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(CPU_EXC_VECTOR),
  parameter logic [WIDTH-1:0] PC_LOW     = WIDTH'(CPU_PC_LOW),
  parameter logic [WIDTH-1:0] PC_HIGH    = WIDTH'(CPU_PC_HIGH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             j_en,
  input  logic [WIDTH-1:0] j_target,
  input  logic             jr_en,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_exc,
  output logic             redirect_pending
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fetch_exc_q, fetch_exc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic [WIDTH-1:0] npc;
  npc_src_e         src;
  logic             rd_req;
  logic [WIDTH-1:0] rd_tgt;

  assign pc_plus4 = pc_q + WIDTH'(4);

  npc_select #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_select (
    .pc          (pc_q),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .j_en        (j_en),
    .j_target    (j_target),
    .jr_en       (jr_en),
    .jr_target   (jr_target),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc_in      (epc_in),
    .pend_valid  (pend_valid_q),
    .pend_target (pend_target_q),
    .npc         (npc),
    .src         (src),
    .rd_req      (rd_req),
    .rd_tgt      (rd_tgt)
  );

  // Legality is evaluated on the incoming PC so the flag always travels with the pc it describes.
  always_comb begin
    pc_d        = npc;
    fetch_exc_d = (npc[1:0] != 2'b00) || (npc < PC_LOW) || (npc > PC_HIGH);
  end

  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    unique case (src)
      NPC_HOLD: begin
        if (rd_req) begin
          pend_valid_d  = 1'b1;
          pend_target_d = rd_tgt;
        end
      end
      NPC_SEQ: ;
      default: begin
        pend_valid_d  = 1'b0;
        pend_target_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      fetch_exc_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_exc_q   <= fetch_exc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc               = pc_q;
  assign fetch_exc        = fetch_exc_q;
  assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench: directed sequences with literal expectations plus randomized traffic vs a behavioural model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        j_en = 1'b0;
  logic [31:0] j_target = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_target = '0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc_in = '0;
  logic [31:0] pc, pc_plus4;
  logic        fetch_exc, redirect_pending;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          cmp_en = 1'b0;

  // Reference state
  logic [31:0] m_pc = 32'h3000;
  logic        m_exc = 1'b0;
  logic        m_pv = 1'b0;
  logic [31:0] m_pt = '0;

  fetch_pc_unit #(
    .WIDTH      (32),
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .PC_LOW     (32'h0000_3000),
    .PC_HIGH    (32'h0000_6FFC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .j_en             (j_en),
    .j_target         (j_target),
    .jr_en            (jr_en),
    .jr_target        (jr_target),
    .exc_req          (exc_req),
    .eret             (eret),
    .epc_in           (epc_in),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .fetch_exc        (fetch_exc),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  function automatic logic illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [31:0] nxt;
    logic        req;
    logic [31:0] tgt;
    if (!reset) begin
      m_pc  <= 32'h3000;
      m_exc <= 1'b0;
      m_pv  <= 1'b0;
      m_pt  <= '0;
    end else begin
      req = jr_en | j_en | br_taken;
      tgt = jr_en ? jr_target : (j_en ? j_target : br_target);
      if (exc_req) begin
        nxt = 32'h4180;
        m_pv <= 1'b0;
      end else if (eret) begin
        nxt = epc_in;
        m_pv <= 1'b0;
      end else if (stall) begin
        nxt = m_pc;
        if (req) begin
          m_pv <= 1'b1;
          m_pt <= tgt;
        end
      end else if (req) begin
        nxt = tgt;
        m_pv <= 1'b0;
      end else if (m_pv) begin
        nxt = m_pt;
        m_pv <= 1'b0;
      end else begin
        nxt = m_pc + 32'd4;
      end
      m_pc  <= nxt;
      m_exc <= illegal(nxt);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc", pc, m_pc);
      chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("model_fetch_exc", {31'd0, fetch_exc}, {31'd0, m_exc});
      chk("model_pending", {31'd0, redirect_pending}, {31'd0, m_pv});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; j_en = 0; jr_en = 0; exc_req = 0; eret = 0;
  endtask

  task automatic expect_state(input string name, input logic [31:0] p, input logic e, input logic pv);
    chk({name, "_pc"}, pc, p);
    chk({name, "_exc"}, {31'd0, fetch_exc}, {31'd0, e});
    chk({name, "_pend"}, {31'd0, redirect_pending}, {31'd0, pv});
  endtask

  function automatic logic [31:0] rand_tgt();
    int unsigned k = $urandom_range(0, 9);
    if (k == 0) return 32'h3000 + ($urandom_range(0, 4095) * 4) + $urandom_range(1, 3);
    if (k == 1) return $urandom();
    return 32'h3000 + ($urandom_range(0, 4095) * 4);
  endfunction

  initial begin
    #2 reset = 1'b0;
    #1;
    expect_state("reset", 32'h3000, 1'b0, 1'b0);
    cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b1;
    expect_state("post_reset", 32'h3000, 1'b0, 1'b0);
    tick(); expect_state("seq1", 32'h3004, 1'b0, 1'b0);
    tick(); expect_state("seq2", 32'h3008, 1'b0, 1'b0);
    tick(); expect_state("seq3", 32'h300C, 1'b0, 1'b0);
    tick(); expect_state("seq4", 32'h3010, 1'b0, 1'b0);

    br_taken = 1; br_target = 32'h3100;
    tick(); expect_state("branch", 32'h3100, 1'b0, 1'b0);
    j_en = 1; j_target = 32'h3200;
    tick(); expect_state("jump_beats_branch", 32'h3200, 1'b0, 1'b0);
    idle(); j_en = 1; j_target = 32'h3020;
    tick(); expect_state("jump_3020", 32'h3020, 1'b0, 1'b0);

    idle(); stall = 1; br_taken = 1; br_target = 32'h3400;
    tick(); expect_state("stall_c1", 32'h3020, 1'b0, 1'b1);
    br_taken = 0;
    tick(); expect_state("stall_c2", 32'h3020, 1'b0, 1'b1);
    tick(); expect_state("stall_c3", 32'h3020, 1'b0, 1'b1);
    stall = 0;
    tick(); expect_state("pend_apply", 32'h3400, 1'b0, 1'b0);
    tick(); expect_state("pend_seq", 32'h3404, 1'b0, 1'b0);

    stall = 1; br_taken = 1; br_target = 32'h3400;
    tick(); expect_state("stall_pend", 32'h3404, 1'b0, 1'b1);
    br_taken = 0; exc_req = 1;
    tick(); expect_state("exc_over_stall", 32'h4180, 1'b0, 1'b0);
    idle(); eret = 1; epc_in = 32'h3024;
    tick(); expect_state("eret", 32'h3024, 1'b0, 1'b0);

    idle(); jr_en = 1; jr_target = 32'h3002; j_en = 1; j_target = 32'h3300;
    tick(); expect_state("jr_misaligned", 32'h3002, 1'b1, 1'b0);
    j_en = 0; jr_target = 32'h7000;
    tick(); expect_state("jr_high", 32'h7000, 1'b1, 1'b0);
    jr_target = 32'h6FFC;
    tick(); expect_state("jr_top", 32'h6FFC, 1'b0, 1'b0);
    idle();
    tick(); expect_state("seq_past_top", 32'h7000, 1'b1, 1'b0);
    exc_req = 1; eret = 1; epc_in = 32'h3500;
    tick(); expect_state("exc_beats_eret", 32'h4180, 1'b0, 1'b0);
    idle(); stall = 1; j_en = 1; j_target = 32'h3600;
    tick();
    j_en = 0; br_taken = 1; br_target = 32'h3700;
    tick(); expect_state("pend_overwrite", 32'h4180, 1'b0, 1'b1);
    stall = 0; br_taken = 0; jr_en = 1; jr_target = 32'h3800;
    tick(); expect_state("live_beats_pend", 32'h3800, 1'b0, 1'b0);

    idle();
    for (int i = 0; i < 2000; i++) begin
      stall     = ($urandom_range(0, 99) < 30);
      br_taken  = ($urandom_range(0, 99) < 20);
      j_en      = ($urandom_range(0, 99) < 10);
      jr_en     = ($urandom_range(0, 99) < 8);
      exc_req   = ($urandom_range(0, 99) < 3);
      eret      = ($urandom_range(0, 99) < 4);
      br_target = rand_tgt();
      j_target  = rand_tgt();
      jr_target = rand_tgt();
      epc_in    = rand_tgt();
      tick();
    end

    idle(); j_en = 1; j_target = 32'h3500;
    tick(); expect_state("pre_rst_jump", 32'h3500, 1'b0, 1'b0);
    idle(); stall = 1; br_taken = 1; br_target = 32'h3600;
    tick(); expect_state("pre_rst_pend", 32'h3500, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1 expect_state("async_reset", 32'h3000, 1'b0, 1'b0);
    tick(); idle();
    reset = 1'b1;
    tick(); expect_state("after_reset", 32'h3004, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
